// File: rtl/stim_pkg.sv
// Shared types and constants for the stimulus sequencer.
// The MISR constants serve the optional STIM_SEQUENCER_MISR_EN build.
package stim_pkg;

  typedef enum logic [1:0] {
    MODE_EXHAUSTIVE = 2'd0,
    MODE_WALK1      = 2'd1,
    MODE_STEP       = 2'd2,
    MODE_RSVD       = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_APPLY     = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_SAMPLE    = 3'd3,
    ST_WAIT_STEP = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  // x^32 + x^22 + x^2 + x + 1, with the x^32 term implicit
  localparam logic [31:0] MISR_POLY = 32'h0040_0007;
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/stim_misr.sv
// 32-bit multiple-input signature register compacting DUT responses.
// Load (seed) takes priority over a compaction step.
module stim_misr
  import stim_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [31:0]       signature
);

  logic [31:0] sig_reg;
  logic [31:0] sig_next;

  always_comb begin
    sig_next = sig_reg;
    if (load) begin
      sig_next = MISR_SEED;
    end else if (en) begin
      sig_next = lfsr_step(sig_reg) ^ 32'(data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_reg <= '0;
    end else begin
      sig_reg <= sig_next;
    end
  end

  assign signature = sig_reg;

endmodule

// File: rtl/stim_sequencer.sv
// Stimulus engine: drives exhaustive / walking-one / single-step vectors into a DUT
// and samples its response after a settle delay. Define STIM_SEQUENCER_MISR_EN for a response signature.
module stim_sequencer
  import stim_pkg::*;
#(
  parameter int INPUT_SIZE    = 3,
  parameter int OUTPUT_SIZE   = 1,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic                   step,
  output logic [INPUT_SIZE-1:0]  stim,
  input  logic [OUTPUT_SIZE-1:0] resp,
  output logic                   sample_valid,
  output logic [INPUT_SIZE-1:0]  sample_vec,
  output logic [OUTPUT_SIZE-1:0] sample_resp,
  output logic [INPUT_SIZE:0]    vec_count,
  output logic                   busy,
  output logic                   done
`ifdef STIM_SEQUENCER_MISR_EN
  ,
  output logic [31:0]            signature
`endif
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [INPUT_SIZE-1:0] VEC_ONES  = '1;
  localparam logic [INPUT_SIZE-1:0] WALK_LAST = INPUT_SIZE'(1) << (INPUT_SIZE - 1);

  state_t                 state_reg, state_next;
  mode_t                  mode_reg, mode_next;
  logic [INPUT_SIZE-1:0]  vec_reg, vec_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [INPUT_SIZE-1:0]  stim_reg, stim_next;
  logic                   svalid_reg, svalid_next;
  logic [INPUT_SIZE-1:0]  svec_reg, svec_next;
  logic [OUTPUT_SIZE-1:0] sresp_reg, sresp_next;
  logic [INPUT_SIZE:0]    count_reg, count_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;

  mode_t                 start_mode;
  logic [INPUT_SIZE-1:0] first_vec;
  logic                  is_last;

  // Reserved mode code behaves as exhaustive
  assign start_mode = (mode == MODE_RSVD) ? MODE_EXHAUSTIVE : mode_t'(mode);
  assign first_vec  = (start_mode == MODE_WALK1) ? INPUT_SIZE'(1) : '0;
  assign is_last    = (mode_reg == MODE_WALK1) ? (vec_reg == WALK_LAST) : (vec_reg == VEC_ONES);

  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    vec_next    = vec_reg;
    cnt_next    = cnt_reg;
    stim_next   = stim_reg;
    svalid_next = 1'b0;
    svec_next   = svec_reg;
    sresp_next  = sresp_reg;
    count_next  = count_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;

    if (state_reg != ST_IDLE && abort) begin
      state_next = ST_IDLE;
      stim_next  = '0;
      busy_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            mode_next  = start_mode;
            vec_next   = first_vec;
            count_next = '0;
            busy_next  = 1'b1;
            state_next = ST_APPLY;
          end
        end
        ST_APPLY: begin
          stim_next  = vec_reg;
          cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
          state_next = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_reg == '0) begin
            state_next = ST_SAMPLE;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        ST_SAMPLE: begin
          svalid_next = 1'b1;
          svec_next   = stim_reg;
          sresp_next  = resp;
          count_next  = count_reg + 1'b1;
          if (is_last) begin
            state_next = ST_FINISH;
          end else begin
            vec_next   = (mode_reg == MODE_WALK1) ? (vec_reg << 1) : (vec_reg + 1'b1);
            state_next = (mode_reg == MODE_STEP) ? ST_WAIT_STEP : ST_APPLY;
          end
        end
        ST_WAIT_STEP: begin
          if (step) begin
            state_next = ST_APPLY;
          end
        end
        ST_FINISH: begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          vec_next   = '0;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      mode_reg   <= MODE_EXHAUSTIVE;
      vec_reg    <= '0;
      cnt_reg    <= '0;
      stim_reg   <= '0;
      svalid_reg <= 1'b0;
      svec_reg   <= '0;
      sresp_reg  <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      vec_reg    <= vec_next;
      cnt_reg    <= cnt_next;
      stim_reg   <= stim_next;
      svalid_reg <= svalid_next;
      svec_reg   <= svec_next;
      sresp_reg  <= sresp_next;
      count_reg  <= count_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign stim         = stim_reg;
  assign sample_valid = svalid_reg;
  assign sample_vec   = svec_reg;
  assign sample_resp  = sresp_reg;
  assign vec_count    = count_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

`ifdef STIM_SEQUENCER_MISR_EN
  logic misr_load;
  logic misr_en;

  // Compaction happens on exactly the cycles that register a sample
  assign misr_load = (state_reg == ST_IDLE) && start;
  assign misr_en   = (state_reg == ST_SAMPLE) && !abort;

  stim_misr #(
    .DATA_W(OUTPUT_SIZE)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (misr_load),
    .en        (misr_en),
    .data      (resp),
    .signature (signature)
  );
`endif

endmodule

// File: doc/stim_sequencer.md
Name: stim_sequencer

Overview:
- Synthesizable, parametrised stimulus engine that drives a combinational or registered DUT and captures its responses.
- Supports exhaustive, walking-one and single-step vector sequences, each with a programmable settle time.
- Sits between board switches/buttons (or a bench) and a `top` DUT. Lets labs run on FPGA without a simulator-only stimulus block.

Parameters:
- INPUT_SIZE, 3, width of stimulus vector driven to the DUT (1..16).
- OUTPUT_SIZE, 1, width of DUT response captured (1..32).
- SETTLE_CYCLES, 4, clock cycles between applying a vector and sampling the response (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a run when idle.
- abort  in  1  single-cycle pulse; terminates a run.
- mode  in  2  sequence select: 0 exhaustive, 1 walking-one, 2 single-step, 3 reserved (treated as 0).
- step  in  1  single-cycle pulse; advances one vector in single-step mode.
- stim  out  INPUT_SIZE  vector applied to the DUT.
- resp  in  OUTPUT_SIZE  DUT output.
- sample_valid  out  1  one-cycle pulse; sample_vec and sample_resp are valid.
- sample_vec  out  INPUT_SIZE  vector that produced sample_resp.
- sample_resp  out  OUTPUT_SIZE  registered DUT response.
- vec_count  out  INPUT_SIZE+1  number of vectors sampled in the current/last run.
- busy  out  1  high from the cycle after an accepted start until done or abort.
- done  out  1  one-cycle pulse when the last vector has been sampled.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0 and the FSM is in IDLE.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, WAIT_STEP, FINISH.
- IDLE:
  - On start, latch mode, clear vec_count, load the first vector and go to APPLY.
  - First vector is 0 in exhaustive mode, 1 in walking-one mode, 0 in single-step mode.
- APPLY: stim <= current vector; load the settle counter with SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: decrement the counter. At 0, go to SAMPLE.
  - Result: resp is sampled exactly SETTLE_CYCLES+1 clocks after stim changes.
- SAMPLE:
  - Register sample_resp <= resp and sample_vec <= stim.
  - Pulse sample_valid; vec_count += 1.
  - If the current vector is the last one, go to FINISH.
  - Otherwise advance the vector: +1 for exhaustive and single-step, shift left by 1 for walking-one.
  - Next state is APPLY for exhaustive/walking-one, WAIT_STEP for single-step.
- Last vector: 2^INPUT_SIZE-1 (exhaustive, single-step); 1<<(INPUT_SIZE-1) (walking-one).
- Final vec_count: 2^INPUT_SIZE for exhaustive, INPUT_SIZE for walking-one.
- WAIT_STEP: hold stim. On step, go to APPLY. Step in any other state is ignored.
- FINISH: pulse done for one cycle, busy <= 0, return to IDLE.
  - stim holds the last vector.
  - sample_* and vec_count hold their values until the next start.
- Input precedence:
  - start while busy is ignored.
  - abort in any non-IDLE state wins over every other transition.
  - abort forces IDLE next cycle with stim <= 0, busy <= 0, no done pulse; vec_count holds.
  - abort and start in the same IDLE cycle: start wins.
- Counter width: INPUT_SIZE+1 bits, so the 2^INPUT_SIZE terminal count does not wrap. The vector register wraps to 0 only after FINISH, never mid-run.
- rst_n asserted mid-run: immediate IDLE, all outputs 0, no done.

Optional Feature:
- Macro: STIM_SEQUENCER_MISR_EN.
- With the macro:
  - Adds output `signature` [31:0].
  - 32-bit MISR, polynomial x^32+x^22+x^2+x+1, seed 32'hFFFFFFFF, loaded on an accepted start.
  - Each SAMPLE cycle: signature <= lfsr_step(signature) ^ zero_extend(resp).
  - Holds after done/abort; 0 on reset.
- Without the macro: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package stim_pkg:
  - mode encodings MODE_EXHAUSTIVE=2'd0, MODE_WALK1=2'd1, MODE_STEP=2'd2.
  - FSM state encoding (3-bit).
  - MISR polynomial constant and seed.
- Sub-module stim_misr (parametrised data width, combinational next-state plus register). Instantiated only under STIM_SEQUENCER_MISR_EN.

Test Plan:
- INPUT_SIZE=3, SETTLE_CYCLES=4, mode 0, DUT y=^a:
  - exactly 8 sample_valid pulses, sample_vec 0..7, sample_resp 0,1,1,0,1,0,0,1.
  - done 1 cycle after the 8th sample; vec_count=8.
- Mode 1, INPUT_SIZE=4:
  - sample_vec 0001,0010,0100,1000; vec_count=4.
  - stim changes every SETTLE_CYCLES+2 clocks.
- Mode 2: start then 3 step pulses spaced 20 cycles apart:
  - 4 samples (vectors 0..3); busy stays high; no done.
  - step pulses while in SETTLE are ignored.
- abort asserted on the 3rd SETTLE cycle of vector 5 (mode 0):
  - next cycle busy=0, stim=0, no done pulse, vec_count=5.
  - a subsequent start restarts from vector 0.
- rst_n low for 1 cycle mid-SETTLE: all outputs 0 asynchronously; start mid-run while busy has no effect.
- MISR_EN, INPUT_SIZE=2, DUT y=a: signature equals the bench reference model after 4 samples; re-running the same sequence gives an identical value.
